// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the op encodings seen on the control-unit interface, the sequencer
// state encoding, and the default watchdog sizing.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVM = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M_RUN = 3'd1,
    S_D_CLR = 3'd2,
    S_D_RUN = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5,
    S_EXC   = 3'd6
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned CNT_W_DEF          = 7;

endpackage

// File: rtl/run_watchdog.sv
// Run-state cycle counter with expiry compare.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - zero the counter (has priority over en)
//   en        - count this cycle; also qualifies expired
//   expired   - high while enabled on the last permitted run cycle
module run_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The run state is left on expiry, so the counter never runs past this value.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiply and divide units for the main control FSM.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start, op             - request pulse and op (00 none, 01 MULT, 10 DIV, 11 DIVM)
//   abort                 - exception flush, cancels any operation
//   mult_end              - multiplier completion
//   div_done, div_by0     - divider completion and zero-divisor flag
//   mult_control, div_op  - run enables
//   div_reset             - divider clear pulse
//   hilo_sel, divm_mode   - HI/LO source (1 = div) and DIVM operand path
//   hi_w, lo_w            - HI/LO write strobes
//   busy, done            - operation in progress, completion pulse
//   exc_div0, timeout     - divide-by-zero and watchdog-expiry pulses
// All outputs are registered, decoded from the next state.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
  input  logic       mult_end,
  input  logic       div_done,
  input  logic       div_by0,
  output logic       mult_control,
  output logic       div_op,
  output logic       div_reset,
  output logic       hilo_sel,
  output logic       divm_mode,
  output logic       hi_w,
  output logic       lo_w,
  output logic       busy,
  output logic       done,
  output logic       exc_div0,
  output logic       timeout
);

  state_e state_q, state_d;
  logic   exc_is_div0;
  logic   wd_clr, wd_en, wd_expired;

  logic hilo_sel_q, hilo_sel_d;
  logic divm_mode_q, divm_mode_d;
  logic mult_control_q, mult_control_d;
  logic div_op_q, div_op_d;
  logic div_reset_q, div_reset_d;
  logic hilo_w_q, hilo_w_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic exc_div0_q, exc_div0_d;
  logic timeout_q, timeout_d;

  run_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign wd_en = (state_q == S_M_RUN) || (state_q == S_D_RUN);

  always_comb begin
    state_d     = state_q;
    exc_is_div0 = 1'b0;
    wd_clr      = 1'b0;
    hilo_sel_d  = hilo_sel_q;
    divm_mode_d = divm_mode_q;

    case (state_q)
      S_IDLE: begin
        if (!abort && start && (op != OP_NONE)) begin
          wd_clr = 1'b1;
          if (op == OP_MULT) begin
            state_d    = S_M_RUN;
            hilo_sel_d = 1'b0;
          end else begin
            state_d     = S_D_CLR;
            hilo_sel_d  = 1'b1;
            divm_mode_d = (op == OP_DIVM);
          end
        end
      end
      S_M_RUN: begin
        if (abort)           state_d = S_IDLE;
        else if (mult_end)   state_d = S_WRITE;
        else if (wd_expired) state_d = S_EXC;
      end
      S_D_CLR: begin
        state_d = abort ? S_IDLE : S_D_RUN;
      end
      S_D_RUN: begin
        // Zero divisor outranks a simultaneous done; completion outranks expiry.
        if (abort) begin
          state_d = S_IDLE;
        end else if (div_by0) begin
          state_d     = S_EXC;
          exc_is_div0 = 1'b1;
        end else if (div_done) begin
          state_d = S_WRITE;
        end else if (wd_expired) begin
          state_d = S_EXC;
        end
      end
      S_WRITE: begin
        state_d = abort ? S_IDLE : S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      divm_mode_d = 1'b0;
    end

    mult_control_d = (state_d == S_M_RUN);
    div_op_d       = (state_d == S_D_RUN);
    div_reset_d    = (state_d == S_D_CLR);
    hilo_w_d       = (state_d == S_WRITE);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_FIN);
    exc_div0_d     = (state_d == S_EXC) && exc_is_div0;
    timeout_d      = (state_d == S_EXC) && !exc_is_div0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      hilo_sel_q     <= 1'b0;
      divm_mode_q    <= 1'b0;
      mult_control_q <= 1'b0;
      div_op_q       <= 1'b0;
      div_reset_q    <= 1'b0;
      hilo_w_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      exc_div0_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hilo_sel_q     <= hilo_sel_d;
      divm_mode_q    <= divm_mode_d;
      mult_control_q <= mult_control_d;
      div_op_q       <= div_op_d;
      div_reset_q    <= div_reset_d;
      hilo_w_q       <= hilo_w_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      exc_div0_q     <= exc_div0_d;
      timeout_q      <= timeout_d;
    end
  end

  assign mult_control = mult_control_q;
  assign div_op       = div_op_q;
  assign div_reset    = div_reset_q;
  assign hilo_sel     = hilo_sel_q;
  assign divm_mode    = divm_mode_q;
  assign hi_w         = hilo_w_q;
  assign lo_w         = hilo_w_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign exc_div0     = exc_div0_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: default-sized instance plus a
// short-watchdog instance (TIMEOUT_CYCLES=8) sharing the same inputs.
module tb_muldiv_sequencer;

  logic       clk, reset, start, abort, mult_end, div_done, div_by0;
  logic [1:0] op;

  logic mult_control, div_op, div_reset, hilo_sel, divm_mode;
  logic hi_w, lo_w, busy, done, exc_div0, timeout;
  logic w_mult_control, w_div_op, w_div_reset, w_hilo_sel, w_divm_mode;
  logic w_hi_w, w_lo_w, w_busy, w_done, w_exc_div0, w_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Output vector bit weights:
  // {mult_control, div_op, div_reset, hilo_sel, divm_mode, hi_w, lo_w, busy, done, exc_div0, timeout}
  localparam logic [10:0] MC = 11'h400, DO = 11'h200, DR = 11'h100, HS = 11'h080;
  localparam logic [10:0] DM = 11'h040, HW = 11'h020, LW = 11'h010, BZ = 11'h008;
  localparam logic [10:0] DN = 11'h004, E0 = 11'h002, TO = 11'h001, NONE = 11'h000;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
    .mult_end(mult_end), .div_done(div_done), .div_by0(div_by0),
    .mult_control(mult_control), .div_op(div_op), .div_reset(div_reset),
    .hilo_sel(hilo_sel), .divm_mode(divm_mode), .hi_w(hi_w), .lo_w(lo_w),
    .busy(busy), .done(done), .exc_div0(exc_div0), .timeout(timeout)
  );

  muldiv_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut_wd (
    .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
    .mult_end(mult_end), .div_done(div_done), .div_by0(div_by0),
    .mult_control(w_mult_control), .div_op(w_div_op), .div_reset(w_div_reset),
    .hilo_sel(w_hilo_sel), .divm_mode(w_divm_mode), .hi_w(w_hi_w), .lo_w(w_lo_w),
    .busy(w_busy), .done(w_done), .exc_div0(w_exc_div0), .timeout(w_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {mult_control, div_op, div_reset, hilo_sel, divm_mode,
            hi_w, lo_w, busy, done, exc_div0, timeout};
  endfunction

  function automatic logic [10:0] w_outs();
    return {w_mult_control, w_div_op, w_div_reset, w_hilo_sel, w_divm_mode,
            w_hi_w, w_lo_w, w_busy, w_done, w_exc_div0, w_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; abort = 1'b0;
    mult_end = 1'b0; div_done = 1'b0; div_by0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (outs() !== NONE) $display("FAIL reset_idle: got %b want %b", outs(), NONE);
    else n_pass++;
    n_checks++;
    if (w_outs() !== NONE) $display("FAIL reset_idle_wd: got %b want %b", w_outs(), NONE);
    else n_pass++;
    // DIV into D_RUN, then reset mid-cycle
    start = 1'b1; op = 2'b10;
    tick();
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (outs() !== (DR | BZ | HS)) $display("FAIL reset_dclr: got %b want %b", outs(), DR | BZ | HS);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== (DO | BZ | HS)) $display("FAIL reset_drun: got %b want %b", outs(), DO | BZ | HS);
    else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== NONE) $display("FAIL reset_async: got %b want %b", outs(), NONE);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (outs() !== (MC | BZ)) $display("FAIL reset_restart: got %b want %b", outs(), MC | BZ);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (outs() !== NONE) $display("FAIL reset_abort: got %b want %b", outs(), NONE);
    else n_pass++;
  endtask

  task automatic test_mult();
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; op = 2'b00;
    for (int c = 1; c <= 33; c++) begin
      n_checks++;
      if (outs() !== (MC | BZ)) $display("FAIL mult_run c%0d: got %b want %b", c, outs(), MC | BZ);
      else n_pass++;
      if (c == 33) mult_end = 1'b1;
      tick();
    end
    mult_end = 1'b0;
    n_checks++;
    if (outs() !== (HW | LW | BZ)) $display("FAIL mult_write: got %b want %b", outs(), HW | LW | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== (DN | BZ)) $display("FAIL mult_done: got %b want %b", outs(), DN | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== NONE) $display("FAIL mult_idle: got %b want %b", outs(), NONE);
    else n_pass++;
  endtask

  task automatic test_div();
    start = 1'b1; op = 2'b10;
    tick();
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (outs() !== (DR | BZ | HS)) $display("FAIL div_clr: got %b want %b", outs(), DR | BZ | HS);
    else n_pass++;
    tick();
    for (int c = 2; c <= 10; c++) begin
      n_checks++;
      if (outs() !== (DO | BZ | HS)) $display("FAIL div_run c%0d: got %b want %b", c, outs(), DO | BZ | HS);
      else n_pass++;
      if (c == 10) div_done = 1'b1;
      tick();
    end
    div_done = 1'b0;
    n_checks++;
    if (outs() !== (HW | LW | BZ | HS)) $display("FAIL div_write: got %b want %b", outs(), HW | LW | BZ | HS);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== (DN | BZ | HS)) $display("FAIL div_done: got %b want %b", outs(), DN | BZ | HS);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== HS) $display("FAIL div_idle: got %b want %b", outs(), HS);
    else n_pass++;
  endtask

  task automatic test_divm_div0();
    start = 1'b1; op = 2'b11;
    tick();
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (outs() !== (DR | BZ | HS | DM)) $display("FAIL divm_clr: got %b want %b", outs(), DR | BZ | HS | DM);
    else n_pass++;
    tick();
    for (int c = 2; c <= 5; c++) begin
      n_checks++;
      if (outs() !== (DO | BZ | HS | DM)) $display("FAIL divm_run c%0d: got %b want %b", c, outs(), DO | BZ | HS | DM);
      else n_pass++;
      if (c == 5) begin
        div_by0 = 1'b1;
        div_done = 1'b1;
      end
      tick();
    end
    div_by0 = 1'b0; div_done = 1'b0;
    n_checks++;
    if (outs() !== (E0 | BZ | HS | DM)) $display("FAIL divm_exc: got %b want %b", outs(), E0 | BZ | HS | DM);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== HS) $display("FAIL divm_idle: got %b want %b", outs(), HS);
    else n_pass++;
  endtask

  task automatic test_ignored_starts();
    do_reset();
    start = 1'b1; op = 2'b01;
    tick();
    op = 2'b10;              // start held high with DIV while busy
    n_checks++;
    if (outs() !== (MC | BZ)) $display("FAIL ign_busy1: got %b want %b", outs(), MC | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== (MC | BZ)) $display("FAIL ign_busy2: got %b want %b", outs(), MC | BZ);
    else n_pass++;
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    n_checks++;
    if (outs() !== (HW | LW | BZ)) $display("FAIL ign_write: got %b want %b", outs(), HW | LW | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== (DN | BZ)) $display("FAIL ign_done: got %b want %b", outs(), DN | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (outs() !== NONE) $display("FAIL ign_start_at_done: got %b want %b", outs(), NONE);
    else n_pass++;
    tick();
    start = 1'b0; op = 2'b00;
    n_checks++;
    if (outs() !== (DR | BZ | HS)) $display("FAIL b2b_accept: got %b want %b", outs(), DR | BZ | HS);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (outs() !== HS) $display("FAIL abort_dclr: got %b want %b", outs(), HS);
    else n_pass++;
    start = 1'b1; op = 2'b00;
    tick();
    n_checks++;
    if (outs() !== HS) $display("FAIL ign_op_none: got %b want %b", outs(), HS);
    else n_pass++;
    op = 2'b01; abort = 1'b1;
    tick();
    start = 1'b0; op = 2'b00; abort = 1'b0;
    n_checks++;
    if (outs() !== HS) $display("FAIL abort_blocks_start: got %b want %b", outs(), HS);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    do_reset();
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; op = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (w_outs() !== (MC | BZ)) $display("FAIL wd_run c%0d: got %b want %b", c, w_outs(), MC | BZ);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (w_outs() !== (TO | BZ)) $display("FAIL wd_timeout: got %b want %b", w_outs(), TO | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (w_outs() !== NONE) $display("FAIL wd_idle: got %b want %b", w_outs(), NONE);
    else n_pass++;
    // second run, aborted at c4
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; op = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (w_outs() !== (MC | BZ)) $display("FAIL wd_run2 c%0d: got %b want %b", c, w_outs(), MC | BZ);
      else n_pass++;
      if (c == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    n_checks++;
    if (w_outs() !== NONE) $display("FAIL wd_abort: got %b want %b", w_outs(), NONE);
    else n_pass++;
    tick();
    n_checks++;
    if (w_outs() !== NONE) $display("FAIL wd_abort_quiet: got %b want %b", w_outs(), NONE);
    else n_pass++;
    // third run: completion on the expiry cycle wins
    start = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; op = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (w_outs() !== (MC | BZ)) $display("FAIL wd_run3 c%0d: got %b want %b", c, w_outs(), MC | BZ);
      else n_pass++;
      if (c == 8) mult_end = 1'b1;
      tick();
    end
    mult_end = 1'b0;
    n_checks++;
    if (w_outs() !== (HW | LW | BZ)) $display("FAIL wd_edge_write: got %b want %b", w_outs(), HW | LW | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (w_outs() !== (DN | BZ)) $display("FAIL wd_edge_done: got %b want %b", w_outs(), DN | BZ);
    else n_pass++;
    tick();
    n_checks++;
    if (w_outs() !== NONE) $display("FAIL wd_edge_idle: got %b want %b", w_outs(), NONE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divm_div0();
    test_ignored_starts();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

endmodule
